// File: rtl/weighted_output_arbiter.sv
// rtl/weighted_output_arbiter.sv - packet output arbiter, fixed priority or weighted round robin
//
// Grants one of NUM_PORTS requesters and holds the grant until the packet ends.
// Optional starvation aging is compiled in with macro ARB_AGING_EN.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   i_req        per-port request, bit i = port i
//   i_weights    port i priority/weight at [i*PRI_W +: PRI_W]
//   i_mode       0 = fixed priority, 1 = weighted round robin (sampled in IDLE only)
//   i_pkt_end    granted packet completes this cycle; releases the grant
//   o_grant      index of the granted port (keeps last value when idle)
//   o_grant_vld  grant is valid and held
module weighted_output_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int PRI_W     = 3,
  parameter int AGE_LIMIT = 63,
  localparam int PORT_W   = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       i_req,
  input  logic [NUM_PORTS*PRI_W-1:0] i_weights,
  input  logic                       i_mode,
  input  logic                       i_pkt_end,
  output logic [PORT_W-1:0]          o_grant,
  output logic                       o_grant_vld
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PORT_W-1:0]   r_grant;
  logic [PORT_W-1:0]   r_ptr;
  logic [PRI_W:0]      r_cred;

  logic                w_arb;
  logic [PORT_W-1:0]   w_fix_port;
  logic [PRI_W-1:0]    w_fix_wt;
  logic                w_fix_found;
  logic [PRI_W-1:0]    w_ptr_wt;
  logic [PORT_W-1:0]   w_wrr_port;
  logic [PORT_W-1:0]   w_cand;
  logic                w_wrr_found;
  logic [PRI_W:0]      w_wrr_cred;
  logic                w_aged_found;
  logic [PORT_W-1:0]   w_aged_port;

  assign w_arb       = (r_state == S_IDLE) && (|i_req);
  assign o_grant     = r_grant;
  assign o_grant_vld = (r_state == S_HOLD);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; pkt_end only matters while holding a grant
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|i_req)   w_state_nxt = S_HOLD;
      S_HOLD:  if (i_pkt_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fixed priority: strict '>' keeps the lowest index on equal weights
  always_comb begin
    w_fix_port  = '0;
    w_fix_wt    = '0;
    w_fix_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i_req[i] && (!w_fix_found || (i_weights[i*PRI_W +: PRI_W] > w_fix_wt))) begin
        w_fix_found = 1'b1;
        w_fix_wt    = i_weights[i*PRI_W +: PRI_W];
        w_fix_port  = PORT_W'(i);
      end
    end
  end

  // WRR: stay on ptr while it requests and has credit, else scan ptr+1.. wrapping to ptr
  always_comb begin
    w_ptr_wt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PORT_W'(i) == r_ptr) w_ptr_wt = i_weights[i*PRI_W +: PRI_W];
    end
    w_wrr_port  = r_ptr;
    w_wrr_cred  = r_cred + 1'b1;
    w_wrr_found = 1'b0;
    w_cand      = '0;
    if (!(i_req[r_ptr] && (r_cred <= {1'b0, w_ptr_wt}))) begin
      w_wrr_cred = (PRI_W+1)'(1);
      for (int k = 1; k <= NUM_PORTS; k++) begin
        w_cand = PORT_W'((int'(r_ptr) + k) % NUM_PORTS);
        if (!w_wrr_found && i_req[w_cand]) begin
          w_wrr_found = 1'b1;
          w_wrr_port  = w_cand;
        end
      end
    end
  end

`ifdef ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] r_age [NUM_PORTS];

  // Lowest-index requester that has waited AGE_LIMIT cycles overrides both modes
  always_comb begin
    w_aged_found = 1'b0;
    w_aged_port  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_aged_found && i_req[i] && (r_age[i] >= AGE_W'(AGE_LIMIT))) begin
        w_aged_found = 1'b1;
        w_aged_port  = PORT_W'(i);
      end
    end
  end

  // Ages count waiting cycles, saturating at AGE_LIMIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!i_req[i] || (o_grant_vld && (r_grant == PORT_W'(i))))
          r_age[i] <= '0;
        else if (r_age[i] < AGE_W'(AGE_LIMIT))
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
`else
  assign w_aged_found = 1'b0;
  assign w_aged_port  = '0;
`endif

  // Grant register plus WRR pointer/credit; fixed-mode wins leave ptr/cred alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_cred  <= '0;
    end else if (w_arb) begin
      if (w_aged_found) begin
        r_grant <= w_aged_port;
        if (i_mode) begin
          r_ptr  <= w_aged_port;
          r_cred <= (PRI_W+1)'(1);
        end
      end else if (i_mode) begin
        r_grant <= w_wrr_port;
        r_ptr   <= w_wrr_port;
        r_cred  <= w_wrr_cred;
      end else begin
        r_grant <= w_fix_port;
      end
    end
  end

endmodule

// File: tb/tb_weighted_output_arbiter.sv
// tb/tb_weighted_output_arbiter.sv - self-checking bench for weighted_output_arbiter
module tb_weighted_output_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] weights = '0;
  logic        mode = 1'b0;
  logic        pkt_end = 1'b0;
  logic [1:0]  grant;
  logic        grant_vld;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference state: whether a grant is held, who holds it, WRR ptr/credit, waiting ages
  bit m_busy  = 1'b0;
  int m_grant = 0;
  int m_ptr   = 0;
  int m_cred  = 0;
  int m_age [4] = '{0, 0, 0, 0};

  weighted_output_arbiter #(
    .NUM_PORTS (4),
    .PRI_W     (3),
    .AGE_LIMIT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (req),
    .i_weights   (weights),
    .i_mode      (mode),
    .i_pkt_end   (pkt_end),
    .o_grant     (grant),
    .o_grant_vld (grant_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int wt(input int i);
    return int'(weights[i*3 +: 3]);
  endfunction

  task automatic setw(input int i, input int v);
    weights[i*3 +: 3] = 3'(v);
  endtask

  // Inputs change 2 time units after the falling edge; outputs are compared at the falling edge
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Behavioural reference
  always @(posedge clk or posedge reset) begin
    int  win;
`ifdef ARB_AGING_EN
    bit  ob;
    int  og;
`endif
    if (reset) begin
      m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_cred = 0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
    end else begin
`ifdef ARB_AGING_EN
      ob = m_busy;
      og = m_grant;
`endif
      win = -1;
      if (!m_busy && req != 4'b0) begin
`ifdef ARB_AGING_EN
        for (int i = 0; i < 4; i++)
          if (win < 0 && req[i] && m_age[i] >= 8) win = i;
        if (win >= 0 && mode) begin m_ptr = win; m_cred = 1; end
`endif
        if (win < 0 && !mode) begin
          for (int i = 0; i < 4; i++)
            if (req[i] && (win < 0 || wt(i) > wt(win))) win = i;
        end else if (win < 0) begin
          if (req[m_ptr] && m_cred <= wt(m_ptr)) begin
            win = m_ptr;
            m_cred++;
          end else begin
            for (int k = 1; k <= 4; k++) begin
              int p;
              p = (m_ptr + k) % 4;
              if (win < 0 && req[p]) win = p;
            end
            m_ptr  = win;
            m_cred = 1;
          end
        end
        m_grant = win;
        m_busy  = 1'b1;
      end else if (m_busy && pkt_end) begin
        m_busy = 1'b0;
      end
`ifdef ARB_AGING_EN
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || (ob && og == i)) m_age[i] = 0;
        else if (m_age[i] < 8)          m_age[i]++;
      end
`endif
    end
  end

  // Cycle-by-cycle compare against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_grant_vld", int'(grant_vld), int'(m_busy));
      chk("model_grant", int'(grant), m_grant);
    end
  end

  initial begin
    int exp034 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    // Reset state
    tick(); tick();
    chk("reset_grant_vld", int'(grant_vld), 0);
    chk("reset_grant", int'(grant), 0);
    chk_en = 1'b1;

    // Fixed priority, highest weight wins
    mode = 1'b0; setw(1, 2); setw(3, 5); req = 4'b1010; reset = 1'b0;
    tick();
    chk("fix_first_vld", int'(grant_vld), 1);
    chk("fix_first_grant", int'(grant), 3);
    pkt_end = 1'b1;
    tick();
    chk("fix_bubble_vld", int'(grant_vld), 0);
    chk("fix_bubble_grant", int'(grant), 3);
    pkt_end = 1'b0;
    tick();
    chk("fix_regrant_vld", int'(grant_vld), 1);
    chk("fix_regrant_grant", int'(grant), 3);

    // Tie goes to lowest index; mode toggle during hold has no effect
    pkt_end = 1'b1; req = 4'b0110; setw(1, 4); setw(2, 4);
    tick();
    pkt_end = 1'b0;
    tick();
    chk("tie_grant", int'(grant), 1);
    mode = 1'b1;
    tick(); tick();
    chk("tie_hold_vld", int'(grant_vld), 1);
    chk("tie_hold_grant", int'(grant), 1);
    mode = 1'b0; pkt_end = 1'b1;
    tick();

    // Asynchronous reset in the middle of a hold on port 2
    pkt_end = 1'b0; req = 4'b0100;
    tick();
    chk("pre_reset_grant", int'(grant), 2);
    reset = 1'b1;
    #1;
    chk("async_reset_vld", int'(grant_vld), 0);
    chk("async_reset_grant", int'(grant), 0);
    tick();

    // WRR, all weights 1: each port gets two grants in turn
    mode = 1'b1; req = 4'b1111; pkt_end = 1'b1;
    for (int i = 0; i < 4; i++) setw(i, 1);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("wrr_seq%0d", k), int'(grant), exp034[k]);
      tick();
    end

    // WRR wrap from ptr=1 to port 3, then port 0 once port 3's credit runs out
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 4'b0010;
    for (int i = 0; i < 4; i++) setw(i, 0);
    setw(3, 1);
    tick();
    chk("wrap_setup", int'(grant), 1);
    tick();
    req = 4'b1001;
    tick(); chk("wrap_a", int'(grant), 3); tick();
    tick(); chk("wrap_b", int'(grant), 3); tick();
    tick(); chk("wrap_c", int'(grant), 0); tick();

`ifdef ARB_AGING_EN
    // Starved port 0 wins once its age reaches the limit
    reset = 1'b1;
    tick();
    mode = 1'b0; weights = '0; setw(1, 7); req = 4'b0011; pkt_end = 1'b1; reset = 1'b0;
    begin
      int exp_age [6] = '{1, 1, 1, 1, 0, 1};
      for (int k = 0; k < 6; k++) begin
        tick();
        chk($sformatf("aging%0d", k), int'(grant), exp_age[k]);
        tick();
      end
    end
`endif

    // Randomised traffic against the reference
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) weights = 12'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      pkt_end = ($urandom_range(0, 2) != 0);
    end
    reset = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
